// File: rtl/slc_control.sv
// Moore control FSM for a small LC-3 style CPU with registered decode outputs.
// Optional PAUSE handling is enabled by defining SLC_PAUSE_EN.
module slc_control #(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       ADDR1MUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       DRMUX,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Halted
);

  typedef enum logic [4:0] {
    S_HALTED, S_F1, S_F2, S_F3, S_DEC,
    S_ADD, S_AND, S_NOT, S_BR, S_BR_T,
    S_JMP, S_JSR, S_JSR2,
    S_LDR1, S_LDR2, S_LDR3,
    S_STR1, S_STR2, S_STR3,
    S_PAUSE1, S_PAUSE2
  } state_t;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_reg;
    logic       ld_pc;
    logic       ld_led;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       addr1mux;
    logic       sr1mux;
    logic       sr2mux;
    logic       drmux;
    logic       mio_en;
    logic       mem_oe;
    logic       mem_we;
    logic       halted;
  } ctl_t;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  ctl_t       ctl;

  // Selects that depend on IR bits are latched with the state they belong to.
  function automatic ctl_t decode(state_t s, logic last,
                                  logic ir5, logic ir11);
    ctl_t c;
    c = '0;
    case (s)
      S_HALTED: c.halted = 1'b1;
      S_F1: begin
        c.gate_pc = 1'b1;
        c.ld_mar  = 1'b1;
        c.ld_pc   = 1'b1;
      end
      S_F2, S_LDR2: begin
        c.mem_oe = 1'b1;
        c.mio_en = 1'b1;
        c.ld_mdr = last;
      end
      S_F3: begin
        c.gate_mdr = 1'b1;
        c.ld_ir    = 1'b1;
      end
      S_DEC: c.ld_ben = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        c.gate_alu = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
        c.sr1mux   = 1'b1;
        c.sr2mux   = ir5;
        c.aluk     = (s == S_ADD) ? 2'b00 :
                     (s == S_AND) ? 2'b01 : 2'b10;
      end
      S_BR_T: begin
        c.ld_pc    = 1'b1;
        c.pcmux    = 2'b10;
        c.addr2mux = 2'b10;
      end
      S_JMP: begin
        c.ld_pc    = 1'b1;
        c.pcmux    = 2'b10;
        c.addr1mux = 1'b1;
      end
      S_JSR: begin
        c.gate_pc = 1'b1;
        c.drmux   = 1'b1;
        c.ld_reg  = 1'b1;
      end
      S_JSR2: begin
        c.ld_pc    = 1'b1;
        c.pcmux    = 2'b10;
        c.addr2mux = ir11 ? 2'b11 : 2'b00;
        c.addr1mux = ~ir11;
      end
      S_LDR1, S_STR1: begin
        c.gate_marmux = 1'b1;
        c.ld_mar      = 1'b1;
        c.addr1mux    = 1'b1;
        c.addr2mux    = 2'b01;
      end
      S_LDR3: begin
        c.gate_mdr = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      S_STR2: begin
        c.gate_alu = 1'b1;
        c.aluk     = 2'b11;
        c.ld_mdr   = 1'b1;
      end
      S_STR3: c.mem_we = 1'b1;
`ifdef SLC_PAUSE_EN
      S_PAUSE1: c.ld_led = 1'b1;
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  logic last;
  assign last = (cnt == WAIT_LAST);

  // Counter is zero outside memory states, so every entry starts clean.
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    case (state)
      S_HALTED: if (Run) state_n = S_F1;
      S_F1:     state_n = S_F2;
      S_F2: begin
        if (last) state_n = S_F3;
        else cnt_n = cnt + 3'd1;
      end
      S_F3:     state_n = S_DEC;
      S_DEC: begin
        unique case (Opcode)
          4'b0001: state_n = S_ADD;
          4'b0101: state_n = S_AND;
          4'b1001: state_n = S_NOT;
          4'b0000: state_n = S_BR;
          4'b1100: state_n = S_JMP;
          4'b0100: state_n = S_JSR;
          4'b0110: state_n = S_LDR1;
          4'b0111: state_n = S_STR1;
`ifdef SLC_PAUSE_EN
          4'b1101: state_n = S_PAUSE1;
`endif
          default: state_n = S_F1;
        endcase
      end
      S_BR:   state_n = BEN ? S_BR_T : S_F1;
      S_JSR:  state_n = S_JSR2;
      S_LDR1: state_n = S_LDR2;
      S_LDR2: begin
        if (last) state_n = S_LDR3;
        else cnt_n = cnt + 3'd1;
      end
      S_STR1: state_n = S_STR2;
      S_STR2: state_n = S_STR3;
      S_STR3: begin
        if (last) state_n = S_F1;
        else cnt_n = cnt + 3'd1;
      end
`ifdef SLC_PAUSE_EN
      S_PAUSE1: if (Continue) state_n = S_PAUSE2;
      S_PAUSE2: if (!Continue) state_n = S_F1;
`endif
      default: state_n = S_F1;
    endcase
  end

`ifndef SLC_PAUSE_EN
  logic unused_continue;
  assign unused_continue = Continue;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_HALTED;
      cnt        <= '0;
      ctl        <= '0;
      ctl.halted <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ctl   <= decode(state_n, cnt_n == WAIT_LAST, IR_5, IR_11);
    end
  end

  assign LD_MAR     = ctl.ld_mar;
  assign LD_MDR     = ctl.ld_mdr;
  assign LD_IR      = ctl.ld_ir;
  assign LD_BEN     = ctl.ld_ben;
  assign LD_CC      = ctl.ld_cc;
  assign LD_REG     = ctl.ld_reg;
  assign LD_PC      = ctl.ld_pc;
  assign LD_LED     = ctl.ld_led;
  assign GatePC     = ctl.gate_pc;
  assign GateMDR    = ctl.gate_mdr;
  assign GateALU    = ctl.gate_alu;
  assign GateMARMUX = ctl.gate_marmux;
  assign PCMUX      = ctl.pcmux;
  assign ADDR2MUX   = ctl.addr2mux;
  assign ALUK       = ctl.aluk;
  assign ADDR1MUX   = ctl.addr1mux;
  assign SR1MUX     = ctl.sr1mux;
  assign SR2MUX     = ctl.sr2mux;
  assign DRMUX      = ctl.drmux;
  assign MIO_EN     = ctl.mio_en;
  assign Mem_OE     = ctl.mem_oe;
  assign Mem_WE     = ctl.mem_we;
  assign Halted     = ctl.halted;

endmodule

// File: tb/tb_slc_control.sv
// Directed scoreboard bench for slc_control (MEM_WAIT=2 main, MEM_WAIT=1 store).
// Pause expectations follow SLC_PAUSE_EN.
module tb_slc_control;

  typedef logic [25:0] vec_t;
  typedef enum {
    E_H, E_F1, E_F2W, E_F2L, E_F3, E_DEC, E_ADD, E_AND, E_NOT,
    E_BR, E_BRT, E_JMP, E_JSR, E_JSR2, E_LA, E_LDR3,
    E_STR2, E_STR3, E_P1, E_P2
  } e_t;

  localparam int MW = 2;

  logic       Clk = 1'b0;
  logic       Reset_n, Run, Continue, IR_5, IR_11, BEN;
  logic       rst1, run1;
  logic [3:0] Opcode;

  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic ADDR1MUX, SR1MUX, SR2MUX, DRMUX, MIO_EN, Mem_OE, Mem_WE, Halted;

  logic b_LD_MAR, b_LD_MDR, b_LD_IR, b_LD_BEN, b_LD_CC, b_LD_REG;
  logic b_LD_PC, b_LD_LED;
  logic b_GatePC, b_GateMDR, b_GateALU, b_GateMARMUX;
  logic [1:0] b_PCMUX, b_ADDR2MUX, b_ALUK;
  logic b_ADDR1MUX, b_SR1MUX, b_SR2MUX, b_DRMUX, b_MIO_EN;
  logic b_Mem_OE, b_Mem_WE, b_Halted;

  slc_control #(.MEM_WAIT(MW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
    .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX),
    .ALUK(ALUK), .ADDR1MUX(ADDR1MUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .DRMUX(DRMUX), .MIO_EN(MIO_EN), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .Halted(Halted)
  );

  slc_control #(.MEM_WAIT(1)) dut1 (
    .Clk(Clk), .Reset_n(rst1), .Run(run1), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(b_LD_MAR), .LD_MDR(b_LD_MDR), .LD_IR(b_LD_IR),
    .LD_BEN(b_LD_BEN), .LD_CC(b_LD_CC), .LD_REG(b_LD_REG),
    .LD_PC(b_LD_PC), .LD_LED(b_LD_LED), .GatePC(b_GatePC),
    .GateMDR(b_GateMDR), .GateALU(b_GateALU), .GateMARMUX(b_GateMARMUX),
    .PCMUX(b_PCMUX), .ADDR2MUX(b_ADDR2MUX), .ALUK(b_ALUK),
    .ADDR1MUX(b_ADDR1MUX), .SR1MUX(b_SR1MUX), .SR2MUX(b_SR2MUX),
    .DRMUX(b_DRMUX), .MIO_EN(b_MIO_EN), .Mem_OE(b_Mem_OE),
    .Mem_WE(b_Mem_WE), .Halted(b_Halted)
  );

  vec_t obs, obs1;
  assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
                LD_LED, GatePC, GateMDR, GateALU, GateMARMUX, PCMUX,
                ADDR2MUX, ALUK, ADDR1MUX, SR1MUX, SR2MUX, DRMUX,
                MIO_EN, Mem_OE, Mem_WE, Halted};
  assign obs1 = {b_LD_MAR, b_LD_MDR, b_LD_IR, b_LD_BEN, b_LD_CC,
                 b_LD_REG, b_LD_PC, b_LD_LED, b_GatePC, b_GateMDR,
                 b_GateALU, b_GateMARMUX, b_PCMUX, b_ADDR2MUX, b_ALUK,
                 b_ADDR1MUX, b_SR1MUX, b_SR2MUX, b_DRMUX, b_MIO_EN,
                 b_Mem_OE, b_Mem_WE, b_Halted};

  always #5 Clk = ~Clk;

  int   errors = 0;
  int   checks = 0;
  vec_t q[$];

  function automatic vec_t ev(e_t s, logic b);
    vec_t v;
    v = '0;
    case (s)
      E_H:    v[0] = 1'b1;
      E_F1:   begin v[17] = 1; v[25] = 1; v[19] = 1; end
      E_F2W:  begin v[2] = 1; v[3] = 1; end
      E_F2L:  begin v[2] = 1; v[3] = 1; v[24] = 1; end
      E_F3:   begin v[16] = 1; v[23] = 1; end
      E_DEC:  v[22] = 1;
      E_ADD, E_AND, E_NOT: begin
        v[15] = 1; v[20] = 1; v[21] = 1; v[6] = 1; v[5] = b;
        v[9:8] = (s == E_ADD) ? 2'b00 : (s == E_AND) ? 2'b01 : 2'b10;
      end
      E_BR:   v = '0;
      E_BRT:  begin v[19] = 1; v[13:12] = 2'b10; v[11:10] = 2'b10; end
      E_JMP:  begin v[19] = 1; v[13:12] = 2'b10; v[7] = 1; end
      E_JSR:  begin v[17] = 1; v[4] = 1; v[20] = 1; end
      E_JSR2: begin
        v[19] = 1; v[13:12] = 2'b10;
        v[11:10] = b ? 2'b11 : 2'b00; v[7] = ~b;
      end
      E_LA:   begin v[14] = 1; v[25] = 1; v[7] = 1; v[11:10] = 2'b01; end
      E_LDR3: begin v[16] = 1; v[20] = 1; v[21] = 1; end
      E_STR2: begin v[15] = 1; v[9:8] = 2'b11; v[24] = 1; end
      E_STR3: v[1] = 1;
      E_P1:   v[18] = 1;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic chk(string tag, vec_t o, vec_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(e_t s, logic b = 1'b0);
    q.push_back(ev(s, b));
  endtask

  task automatic push_mem(e_t w, e_t l);
    for (int i = 0; i < MW; i++) push(w);
    push(l);
  endtask

  task automatic push_fetch();
    push(E_F1);
    push_mem(E_F2W, E_F2L);
    push(E_F3);
    push(E_DEC);
  endtask

  task automatic drain(string tag);
    while (q.size() > 0) begin
      @(posedge Clk);
      #1;
      Run = 1'b0;
      chk(tag, obs, q.pop_front());
    end
  endtask

  task automatic start(string tag, logic [3:0] op);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk({tag, "_rst"}, obs, ev(E_H, 1'b0));
    Opcode = op;
    @(negedge Clk);
    Reset_n = 1'b1;
    push(E_H);
    drain({tag, "_idle"});
    Run = 1'b1;
  endtask

  int we_cnt, oe_cnt;

  initial begin
    Reset_n = 1'b0; Run = 1'b0; Continue = 1'b0;
    IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0; Opcode = 4'h0;
    rst1 = 1'b0; run1 = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset", obs, ev(E_H, 1'b0));

    IR_5 = 1'b1;
    start("add", 4'b0001);
    push_fetch(); push(E_ADD, 1'b1); push(E_F1);
    drain("add");

    IR_5 = 1'b0;
    start("and", 4'b0101);
    push_fetch(); push(E_AND, 1'b0); push(E_F1);
    drain("and");

    start("not", 4'b1001);
    push_fetch(); push(E_NOT, 1'b0); push(E_F1);
    drain("not");

    BEN = 1'b0;
    start("br_nt", 4'b0000);
    push_fetch(); push(E_BR); push(E_F1);
    drain("br_nt");

    BEN = 1'b1;
    start("br_t", 4'b0000);
    push_fetch(); push(E_BR); push(E_BRT); push(E_F1);
    drain("br_t");

    start("jmp", 4'b1100);
    push_fetch(); push(E_JMP); push(E_F1);
    drain("jmp");

    IR_11 = 1'b1;
    start("jsr", 4'b0100);
    push_fetch(); push(E_JSR); push(E_JSR2, 1'b1); push(E_F1);
    drain("jsr");

    IR_11 = 1'b0;
    start("jsrr", 4'b0100);
    push_fetch(); push(E_JSR); push(E_JSR2, 1'b0); push(E_F1);
    drain("jsrr");

    start("ldr", 4'b0110);
    push_fetch(); push(E_LA); push_mem(E_F2W, E_F2L);
    push(E_LDR3); push(E_F1);
    drain("ldr");

    start("str", 4'b0111);
    push_fetch(); push(E_LA); push(E_STR2);
    push_mem(E_STR3, E_STR3); push(E_F1);
    drain("str");

    start("nop", 4'b1111);
    push_fetch(); push(E_F1);
    drain("nop");

    start("pause", 4'b1101);
    push_fetch();
`ifdef SLC_PAUSE_EN
    push(E_P1);
    drain("pause_in");
    repeat (10) push(E_P1);
    drain("pause_hold");
    Continue = 1'b1;
    push(E_P2); push(E_P2);
    drain("pause_cont");
    Continue = 1'b0;
    push(E_F1);
    drain("pause_out");
`else
    push(E_F1);
    drain("pause_nop");
`endif

    start("rst_f2", 4'b0001);
    push(E_F1); push(E_F2W);
    drain("rst_f2");
    #2;
    Reset_n = 1'b0;
    #1;
    chk("rst_f2_async", obs, ev(E_H, 1'b0));

    Opcode = 4'b0111;
    @(negedge Clk);
    rst1 = 1'b1;
    run1 = 1'b1;
    we_cnt = 0;
    oe_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge Clk);
      #1;
      run1 = 1'b0;
      if (i == 3) chk("mw1_f2_last", {31'd0, b_LD_MDR}, 32'd1);
      if (i == 7) chk("mw1_str2", {b_GateALU, b_LD_MDR, b_MIO_EN}, 3'b110);
      if (i >= 6) begin
        we_cnt += int'(b_Mem_WE);
        oe_cnt += int'(b_Mem_OE);
      end
    end
    chk("mw1_we_cycles", vec_t'(we_cnt), vec_t'(2));
    chk("mw1_oe_cycles", vec_t'(oe_cnt), vec_t'(0));
    chk("mw1_back_f1", obs1, ev(E_F1, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=hang expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/slc_control.md
SLC_CONTROL -- requirements
Module: slc_control

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2: extra wait cycles per memory access, legal range 1..7.
REQ-002 SHALL have port Clk, input, 1: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port Run, input, 1: start request from HALTED.
REQ-005 SHALL have port Continue, input, 1: resume from PAUSE.
REQ-006 SHALL have ports Opcode (4 bits, IR[15:12]), IR_5 (1 bit) and IR_11 (1 bit), all inputs: instruction decode fields.
REQ-007 SHALL have port BEN, input, 1: branch enable from the datapath.
REQ-008 SHALL have outputs LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC and LD_LED, 1 bit each: register load strobes.
REQ-009 SHALL have outputs GatePC, GateMDR, GateALU and GateMARMUX, 1 bit each: bus drivers.
REQ-010 SHALL have outputs PCMUX (2), ADDR2MUX (2), ALUK (2), ADDR1MUX, SR1MUX, SR2MUX, DRMUX and MIO_EN (1 each): datapath selects.
REQ-011 SHALL have outputs Mem_OE and Mem_WE, 1 bit each, active-high: memory strobes.
REQ-012 SHALL have output Halted, 1 bit: high only in state HALTED.

Function
REQ-013 SHALL implement Moore control; every output SHALL be a function of current state only, and every output not asserted by a state SHALL be 0.
REQ-014 SHALL use states HALTED, F1, F2, F3, DEC, ADD, AND, NOT, BR, BR_T, JMP, JSR, LDR1, LDR2, LDR3, STR1, STR2, STR3, PAUSE1 and PAUSE2.
REQ-015 HALTED SHALL move to F1 when Run=1 and otherwise hold.
REQ-016 F1 SHALL assert GatePC, LD_MAR, LD_PC and PCMUX=00 (PC<-PC+1), then go to F2.
REQ-017 F2 SHALL assert Mem_OE and MIO_EN for MEM_WAIT+1 cycles, counted by a 3-bit wait counter, with LD_MDR only on the last cycle; it SHALL then go to F3.
REQ-018 F3 SHALL assert GateMDR and LD_IR, then go to DEC.
REQ-019 DEC SHALL assert LD_BEN and dispatch on Opcode: 0001 ADD, 0101 AND, 1001 NOT, 0000 BR, 1100 JMP, 0100 JSR, 0110 LDR1, 0111 STR1, 1101 PAUSE1; all others SHALL go to F1.
REQ-020 ADD, AND and NOT SHALL assert GateALU, LD_REG and LD_CC with ALUK 00, 01 and 10 respectively, SR2MUX=IR_5 and SR1MUX=1, then go to F1.
REQ-021 BR SHALL go to BR_T if BEN=1, else to F1.
REQ-022 BR_T SHALL assert LD_PC, PCMUX=10, ADDR1MUX=0 and ADDR2MUX=10.
REQ-023 JMP SHALL assert LD_PC, PCMUX=10, ADDR1MUX=1 and ADDR2MUX=00.
REQ-024 JSR SHALL assert GatePC, DRMUX=1 (R7) and LD_REG on its first cycle; its second cycle SHALL load PC with ADDR2MUX=11 if IR_11=1, or ADDR1MUX=1 (BaseR) if IR_11=0.
REQ-025 LDR1 SHALL assert GateMARMUX and LD_MAR with ADDR1MUX=1 and ADDR2MUX=01.
REQ-026 LDR2 SHALL perform a memory read per REQ-017.
REQ-027 LDR3 SHALL assert GateMDR, LD_REG and LD_CC.
REQ-028 STR1 SHALL perform the LDR1 address step; STR2 SHALL assert GateALU, ALUK=11 (PASS A) and LD_MDR with MIO_EN=0.
REQ-029 STR3 SHALL assert Mem_WE for MEM_WAIT+1 cycles.
REQ-030 All execute states SHALL return to F1 when finished.
REQ-031 At most one Gate* output SHALL be high in any cycle.
REQ-032 The wait counter SHALL clear on entry to every memory state; no memory state SHALL be re-entered without that clear.

Reset
REQ-033 Reset_n=0 SHALL force state HALTED and a wait count of 0 immediately, independent of Clk, including mid-instruction and mid-memory-access.
REQ-034 During and after reset, all outputs SHALL be 0 except Halted=1.
REQ-035 After Reset_n is released, the block SHALL leave HALTED only on a sampled Run=1.

Configuration
REQ-036 With SLC_PAUSE_EN defined: PAUSE1 SHALL assert LD_LED and hold while Continue=0; Continue=1 SHALL go to PAUSE2; PAUSE2 SHALL hold while Continue=1 and go to F1 when Continue=0.
REQ-037 With SLC_PAUSE_EN undefined: Opcode 1101 SHALL dispatch to F1 as a NOP, and LD_LED SHALL be tied to 0.

Verification
REQ-038 Reset_n=0 during an F2 wait cycle -> HALTED and Halted=1 within the same cycle; all strobes 0.
REQ-039 MEM_WAIT=2, Run pulse, Opcode=0001, IR_5=1 -> sequence F1, F2 x3 (LD_MDR on the third cycle), F3, DEC, ADD (GateALU=LD_REG=LD_CC=1, SR2MUX=1), F1; 8 cycles total.
REQ-040 Opcode=0000 with BEN=0 -> DEC, BR, F1 with LD_PC never asserted; with BEN=1 -> BR_T asserts LD_PC and PCMUX=10.
REQ-041 Opcode=0111, MEM_WAIT=1 -> Mem_WE high for exactly 2 cycles, MIO_EN=0 in STR2, Mem_OE=0 throughout.
REQ-042 SLC_PAUSE_EN defined, Opcode=1101 -> LD_LED high; held with Continue=0 for 10 cycles; Continue 1 then 0 -> F1. With the macro undefined -> DEC then F1 directly.
